// File: rtl/bytestriping_pkg.sv
// Shared constants for the byte striper pair (TX and RX): lane count and the
// idle/pad symbol defaults used to recognise padding on the receive side.
package bytestriping_pkg;

  localparam int          NUM_LANES     = 4;
  localparam logic [7:0]  IDLE_BYTE_DEF = 8'hBC;
  localparam logic [7:0]  PAD_BYTE_DEF  = 8'hF7;

  typedef enum logic {
    EMPTY = 1'b0,
    FILL  = 1'b1
  } stripe_state_t;

  // Lanes at and above n hold padding in a flushed group of n bytes.
  function automatic logic [NUM_LANES-1:0] pad_mask_f(input logic [1:0] n);
    return {NUM_LANES{1'b1}} << n;
  endfunction

endpackage

// File: rtl/bytestriping_tx.sv
// Transmit byte striper: collects one byte per clock into groups of four and
// presents each group across four lanes for one cycle; partial groups are padded on flush.
module bytestriping_tx
  import bytestriping_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] IDLE_BYTE = IDLE_BYTE_DEF,
  parameter logic [WIDTH-1:0] PAD_BYTE  = PAD_BYTE_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     data,
  input  logic                 valid,
  output logic [WIDTH-1:0]     data_out0,
  output logic [WIDTH-1:0]     data_out1,
  output logic [WIDTH-1:0]     data_out2,
  output logic [WIDTH-1:0]     data_out3,
  output logic                 valid_out,
  output logic [NUM_LANES-1:0] pad_mask,
  output logic [7:0]           group_cnt
);

  stripe_state_t                            state;
  logic [1:0]                               ptr;
  logic [NUM_LANES-2:0][WIDTH-1:0]          stg;
  logic [NUM_LANES-1:0][WIDTH-1:0]          lanes;

  assign data_out0 = lanes[0];
  assign data_out1 = lanes[1];
  assign data_out2 = lanes[2];
  assign data_out3 = lanes[3];

  always_ff @(posedge clk) begin
    if (reset) begin
      // Staged bytes are dropped outright; no flush group leaves on reset.
      state     <= EMPTY;
      ptr       <= '0;
      stg       <= '0;
      lanes     <= {NUM_LANES{IDLE_BYTE}};
      valid_out <= 1'b0;
      pad_mask  <= '0;
      group_cnt <= '0;
    end else if (valid) begin
      if (ptr != 2'd3) begin
        for (int i = 0; i < NUM_LANES-1; i++)
          if (ptr == 2'(i)) stg[i] <= data;
        ptr       <= ptr + 2'd1;
        state     <= FILL;
        lanes     <= {NUM_LANES{IDLE_BYTE}};
        valid_out <= 1'b0;
        pad_mask  <= '0;
      end else begin
        lanes     <= {data, stg[2], stg[1], stg[0]};
        valid_out <= 1'b1;
        pad_mask  <= '0;
        ptr       <= '0;
        state     <= EMPTY;
        group_cnt <= group_cnt + 8'd1;
      end
    end else if (state == FILL) begin
      for (int i = 0; i < NUM_LANES; i++)
        lanes[i] <= (2'(i) < ptr && i < NUM_LANES-1) ? stg[i] : PAD_BYTE;
      pad_mask  <= pad_mask_f(ptr);
      valid_out <= 1'b1;
      ptr       <= '0;
      state     <= EMPTY;
      group_cnt <= group_cnt + 8'd1;
    end else begin
      lanes     <= {NUM_LANES{IDLE_BYTE}};
      valid_out <= 1'b0;
      pad_mask  <= '0;
    end
  end

endmodule

// File: tb/tb_bytestriping_tx.sv
// Scoreboard bench for bytestriping_tx: a queue-based byte model predicts groups,
// a negedge monitor checks every cycle's lane outputs against it.
module tb_bytestriping_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data;
  logic       valid;
  logic [7:0] data_out0, data_out1, data_out2, data_out3;
  logic       valid_out;
  logic [3:0] pad_mask;
  logic [7:0] group_cnt;

  bytestriping_tx dut (
    .clk(clk), .reset(reset), .data(data), .valid(valid),
    .data_out0(data_out0), .data_out1(data_out1), .data_out2(data_out2),
    .data_out3(data_out3), .valid_out(valid_out), .pad_mask(pad_mask),
    .group_cnt(group_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0][7:0] lanes;
    logic [3:0]      mask;
    logic [7:0]      cnt;
    logic [31:0]     tag;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] pend[$];
  logic [7:0] mcnt;
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: bytes collect in a list; a group leaves once four are held, or on
  // the first idle cycle with any held. Groups appear right after that edge.
  task automatic step(input logic r, input logic v, input logic [7:0] d);
    exp_t e;
    if (r) begin
      pend.delete();
      mcnt = 8'd0;
    end else if (v) begin
      pend.push_back(d);
      if (pend.size() == 4) begin
        mcnt = mcnt + 8'd1;
        for (int i = 0; i < 4; i++) e.lanes[i] = pend[i];
        e.mask = 4'b0000;
        e.cnt  = mcnt;
        e.tag  = 32'(cyc + 1);
        sb.push_back(e);
        pend.delete();
      end
    end else if (pend.size() > 0) begin
      mcnt = mcnt + 8'd1;
      for (int i = 0; i < 4; i++) begin
        e.lanes[i] = (i < pend.size()) ? pend[i] : 8'hF7;
        e.mask[i]  = (i >= pend.size());
      end
      e.cnt = mcnt;
      e.tag = 32'(cyc + 1);
      sb.push_back(e);
      pend.delete();
    end
    reset = r; valid = v; data = d;
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].tag == 32'(cyc)) begin
      chk("valid_out", {31'd0, valid_out}, 32'd1);
      chk("lane0", {24'd0, data_out0}, {24'd0, sb[0].lanes[0]});
      chk("lane1", {24'd0, data_out1}, {24'd0, sb[0].lanes[1]});
      chk("lane2", {24'd0, data_out2}, {24'd0, sb[0].lanes[2]});
      chk("lane3", {24'd0, data_out3}, {24'd0, sb[0].lanes[3]});
      chk("pad_mask", {28'd0, pad_mask}, {28'd0, sb[0].mask});
      chk("group_cnt", {24'd0, group_cnt}, {24'd0, sb[0].cnt});
      void'(sb.pop_front());
    end else if (cyc > 0) begin
      chk("idle_valid_out", {31'd0, valid_out}, 32'd0);
      chk("idle_lanes", {data_out3, data_out2, data_out1, data_out0}, 32'hBCBCBCBC);
      chk("idle_pad_mask", {28'd0, pad_mask}, 32'd0);
    end
  end

  initial begin
    reset = 1'b1; valid = 1'b0; data = 8'h00; mcnt = 8'd0;
    #1;
    // 1: reset for 3 cycles
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    chk("reset_group_cnt", {24'd0, group_cnt}, 32'd0);
    // 2: one full group
    for (int i = 1; i <= 4; i++) step(1'b0, 1'b1, 8'(i));
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    // 3: two back-to-back groups
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'h10 + 8'(i));
    step(1'b0, 1'b0, 8'h00);
    // 4: two-byte flush, then a byte lands on lane 0
    step(1'b0, 1'b1, 8'hA0);
    step(1'b0, 1'b1, 8'hA1);
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'hB0);
    step(1'b0, 1'b0, 8'h00);
    // one- and three-byte flushes
    step(1'b0, 1'b1, 8'hD0);
    step(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'hE0 + 8'(i));
    step(1'b0, 1'b0, 8'h00);
    // 5: reset with three bytes staged
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'hC0 + 8'(i));
    step(1'b1, 1'b1, 8'hC3);
    step(1'b0, 1'b0, 8'h00);
    chk("reset_mid_group_cnt", {24'd0, group_cnt}, 32'd0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'h50 + 8'(i));
    step(1'b0, 1'b0, 8'h00);
    // random traffic with occasional reset
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, 8'($urandom));
    // 6: 256 full groups back-to-back wrap group_cnt
    step(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 1024; i++) step(1'b0, 1'b1, 8'($urandom));
    step(1'b0, 1'b0, 8'h00);
    chk("wrap_group_cnt", {24'd0, group_cnt}, 32'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
